// File: rtl/dbus_mem_target_pkg.sv
// rtl/dbus_mem_target_pkg.sv - shared CPU bus widths, FSM encodings and legal byte-enable patterns
package dbus_mem_target_pkg;

  // CPU data bus geometry shared by every bus target
  localparam int CPU_ADDR_WIDTH = 32;
  localparam int CPU_DATA_WIDTH = 32;
  localparam int CPU_BEN_WIDTH  = CPU_DATA_WIDTH / 8;

  // Target FSM encodings (kept as plain vectors for the legacy blocks)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Byte-enable patterns an initiator may legally issue: single byte,
  // aligned halfword, or full word
  localparam logic [CPU_BEN_WIDTH-1:0] BEN_B0 = 4'b0001;
  localparam logic [CPU_BEN_WIDTH-1:0] BEN_B1 = 4'b0010;
  localparam logic [CPU_BEN_WIDTH-1:0] BEN_B2 = 4'b0100;
  localparam logic [CPU_BEN_WIDTH-1:0] BEN_B3 = 4'b1000;
  localparam logic [CPU_BEN_WIDTH-1:0] BEN_HL = 4'b0011;
  localparam logic [CPU_BEN_WIDTH-1:0] BEN_HH = 4'b1100;
  localparam logic [CPU_BEN_WIDTH-1:0] BEN_W  = 4'b1111;

  function automatic logic ben_legal(input logic [CPU_BEN_WIDTH-1:0] ben);
    logic ok;
    ok = 1'b0;
    case (ben)
      BEN_B0, BEN_B1, BEN_B2, BEN_B3, BEN_HL, BEN_HH, BEN_W: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dbus_mem_target_ram_be.sv
// rtl/dbus_mem_target_ram_be.sv - single-port synchronous RAM with per-byte write enables
module ram_be
  import dbus_mem_target_pkg::*;
#(
  parameter int MEM_LOG2 = 10
) (
  input  logic                      clk,
  input  logic [MEM_LOG2-1:0]       i_addr,
  input  logic [CPU_BEN_WIDTH-1:0]  i_we,
  input  logic [CPU_DATA_WIDTH-1:0] i_wdata,
  output logic [CPU_DATA_WIDTH-1:0] o_rdata
);

  logic [CPU_DATA_WIDTH-1:0] r_mem [2**MEM_LOG2];
  logic [CPU_DATA_WIDTH-1:0] r_rdata;

  // Read-first port: lanes with their enable set are written, the old word is read out
  always_ff @(posedge clk) begin
    for (int i = 0; i < CPU_BEN_WIDTH; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dbus_mem_target.sv
// rtl/dbus_mem_target.sv - CPU data-bus memory target with programmable wait states
module dbus_mem_target
  import dbus_mem_target_pkg::*;
#(
  parameter int MEM_LOG2    = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [CPU_ADDR_WIDTH-1:0] i_DAddr,
  input  logic                      i_DCmd,
  input  logic                      i_DRnW,
  input  logic [CPU_BEN_WIDTH-1:0]  i_DBen,
  input  logic [CPU_DATA_WIDTH-1:0] i_DData,
  output logic [CPU_DATA_WIDTH-1:0] o_DData,
  output logic                      o_DRdy,
  output logic                      o_DErr
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]                r_state;
  logic [3:0]                r_cnt;
  logic [CPU_ADDR_WIDTH-1:0] r_addr;
  logic                      r_rnw;
  logic [CPU_BEN_WIDTH-1:0]  r_ben;
  logic [CPU_DATA_WIDTH-1:0] r_data;

  logic                      w_resp;
  logic                      w_err;
  logic [MEM_LOG2-1:0]       w_ram_addr;
  logic [CPU_BEN_WIDTH-1:0]  w_ram_we;
  logic [CPU_DATA_WIDTH-1:0] w_ram_rdata;

  // Transaction FSM: capture in IDLE, count wait states, respond for one cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rnw   <= 1'b0;
      r_ben   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_DCmd) begin
            r_addr  <= i_DAddr;
            r_rnw   <= i_DRnW;
            r_ben   <= i_DBen;
            r_data  <= i_DData;
            r_cnt   <= WAIT_INIT;
            r_state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!i_DCmd) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Error decode on the captured request: out-of-range, misaligned or illegal lane mix
  always_comb begin
    w_err = (|(r_addr >> (MEM_LOG2 + 2))) | (|r_addr[1:0]) | ~ben_legal(r_ben);
  end

  // RAM addressing: in IDLE look at the live address so a zero-wait read has data
  // ready in the response cycle; afterwards keep fetching the captured address
  always_comb begin
    w_ram_addr = (r_state == ST_IDLE) ? i_DAddr[MEM_LOG2+1:2] : r_addr[MEM_LOG2+1:2];
    w_ram_we   = (o_DRdy && !r_rnw) ? r_ben : '0;
  end

  // Completion pulses derive from registered state only, never from live inputs
  always_comb begin
    w_resp  = (r_state == ST_RESP);
    o_DRdy  = w_resp & ~w_err;
    o_DErr  = w_resp & w_err;
    o_DData = o_DRdy ? w_ram_rdata : '0;
  end

  ram_be #(
    .MEM_LOG2(MEM_LOG2)
  ) u_ram (
    .clk    (clk),
    .i_addr (w_ram_addr),
    .i_we   (w_ram_we),
    .i_wdata(r_data),
    .o_rdata(w_ram_rdata)
  );

endmodule
